sram_req_arbiter: RTL and testbench

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

---
 rtl/sram_req_arbiter_pkg.sv | 14 +
 rtl/sram_req_arbiter_owner_fifo.sv | 50 +++++
 rtl/sram_req_arbiter.sv | 106 ++++++++++
 tb/tb_sram_req_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_req_arbiter_pkg.sv
// Shared CPU-side arbitration constants: requester owner encodings and outstanding-depth sizing.
// Pure types/constants; no logic, no latency.
package sram_req_arbiter_pkg;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_t;

  localparam int ARB_MAX_OUTSTANDING = 2;
  localparam int ARB_CNT_W           = $clog2(ARB_MAX_OUTSTANDING + 1);
  localparam int ARB_PTR_W           = $clog2(ARB_MAX_OUTSTANDING);

endpackage

// File: rtl/sram_req_arbiter_owner_fifo.sv
// In-order owner-tag FIFO: push/pop take effect at the next clk edge, head is combinational.
// Push when full and pop when empty are dropped.
module arb_owner_fifo
  import sram_req_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 push,
  input  owner_t               tag,
  input  logic                 pop,
  output owner_t               head,
  output logic [ARB_CNT_W-1:0] count,
  output logic                 full,
  output logic                 empty
);

  owner_t               entries [ARB_MAX_OUTSTANDING];
  logic [ARB_PTR_W-1:0] wr_ptr;
  logic [ARB_PTR_W-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  function automatic logic [ARB_PTR_W-1:0] ptr_inc(input logic [ARB_PTR_W-1:0] p);
    return (p == ARB_PTR_W'(ARB_MAX_OUTSTANDING - 1)) ? '0 : p + ARB_PTR_W'(1);
  endfunction

  assign full    = (count == ARB_CNT_W'(ARB_MAX_OUTSTANDING));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = entries[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + ARB_CNT_W'(do_push) - ARB_CNT_W'(do_pop);
    end
  end

  // Payload needs no reset: it is only observed while count says it is valid.
  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= tag;
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Two-requester SRAM-like arbiter (data over inst, or round-robin with SRAM_ARB_ROUND_ROBIN_EN); addr_ok is same-cycle.
// Grant is held until mem_addr_ok; mem_req is withheld while ARB_MAX_OUTSTANDING responses are pending.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  owner_t               sel;
  owner_t               grant;
  owner_t               lock_owner;
  owner_t               head_tag;
  logic                 grant_lock;
  logic                 accept;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ARB_CNT_W-1:0] fifo_count;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  owner_t rr_ptr;

  always_ff @(posedge clk) begin
    if (!resetn)     rr_ptr <= OWNER_DATA;
    else if (accept) rr_ptr <= (grant == OWNER_DATA) ? OWNER_INST : OWNER_DATA;
  end

  always_comb begin
    sel = data_req ? OWNER_DATA : OWNER_INST;
    if (inst_req && data_req) sel = rr_ptr;
  end
`else
  assign sel = data_req ? OWNER_DATA : OWNER_INST;
`endif

  assign grant   = grant_lock ? lock_owner : sel;
  assign mem_req = resetn & (grant_lock | inst_req | data_req)
                 & (fifo_count < ARB_CNT_W'(ARB_MAX_OUTSTANDING));
  assign accept  = mem_req & mem_addr_ok;
  assign pop     = resetn & mem_data_ok & ~fifo_empty;

  assign mem_wr    = (grant == OWNER_DATA) ? data_wr    : inst_wr;
  assign mem_size  = (grant == OWNER_DATA) ? data_size  : inst_size;
  assign mem_addr  = (grant == OWNER_DATA) ? data_addr  : inst_addr;
  assign mem_wstrb = (grant == OWNER_DATA) ? data_wstrb : inst_wstrb;
  assign mem_wdata = (grant == OWNER_DATA) ? data_wdata : inst_wdata;

  assign inst_addr_ok = accept & (grant == OWNER_INST);
  assign data_addr_ok = accept & (grant == OWNER_DATA);
  assign inst_data_ok = pop & (head_tag == OWNER_INST);
  assign data_data_ok = pop & (head_tag == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Once a request is visible on the shared port it may not change owner until accepted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant_lock <= 1'b0;
      lock_owner <= OWNER_DATA;
    end else begin
      grant_lock <= mem_req & ~mem_addr_ok;
      lock_owner <= grant;
    end
  end

  arb_owner_fifo u_owner_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept & ~fifo_full),
    .tag    (grant),
    .pop    (pop),
    .head   (head_tag),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: queue-based reference model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_sram_req_arbiter;
  import sram_req_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  sram_req_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pending responses are a queue of owners; an unaccepted request keeps its owner.
  owner_t mq[$];
  logic   m_lock = 1'b0;
  owner_t m_lock_owner = OWNER_DATA;
  owner_t m_rr = OWNER_DATA;

  initial begin
    owner_t o;
    logic   e_req, e_acc, e_pop;
    owner_t hd;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        chk("m_rst_mem_req", mem_req, 0);
        chk("m_rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        chk("m_rst_data_ok", {inst_data_ok, data_data_ok}, 0);
        mq.delete();
        m_lock = 1'b0;
        m_rr   = OWNER_DATA;
      end else begin
        if (m_lock)                 o = m_lock_owner;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        else if (inst_req && data_req) o = m_rr;
`endif
        else                        o = data_req ? OWNER_DATA : OWNER_INST;
        e_req = (m_lock || inst_req || data_req) && (mq.size() < ARB_MAX_OUTSTANDING);
        e_acc = e_req && mem_addr_ok;
        e_pop = mem_data_ok && (mq.size() > 0);
        hd    = (mq.size() > 0) ? mq[0] : OWNER_INST;
        chk("m_mem_req", mem_req, e_req);
        if (e_req) begin
          chk("m_mem_addr", mem_addr, (o == OWNER_DATA) ? data_addr : inst_addr);
          chk("m_mem_wdata", mem_wdata, (o == OWNER_DATA) ? data_wdata : inst_wdata);
          chk("m_mem_ctl", {mem_wr, mem_size, mem_wstrb},
              (o == OWNER_DATA) ? {data_wr, data_size, data_wstrb} : {inst_wr, inst_size, inst_wstrb});
        end
        chk("m_inst_addr_ok", inst_addr_ok, e_acc && o == OWNER_INST);
        chk("m_data_addr_ok", data_addr_ok, e_acc && o == OWNER_DATA);
        chk("m_inst_data_ok", inst_data_ok, e_pop && hd == OWNER_INST);
        chk("m_data_data_ok", data_data_ok, e_pop && hd == OWNER_DATA);
        chk("m_rdata", {inst_rdata ^ mem_rdata} | {data_rdata ^ mem_rdata}, 0);
        if (e_pop) void'(mq.pop_front());
        if (e_acc) begin
          mq.push_back(o);
          m_rr = (o == OWNER_DATA) ? OWNER_INST : OWNER_DATA;
        end
        m_lock       = e_req && !mem_addr_ok;
        m_lock_owner = o;
      end
    end
  end

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wstrb = 4'h0; inst_wdata = 0;
    data_req = 0; data_wr = 1; data_size = 2'd1; data_addr = 0; data_wstrb = 4'b0011;
    data_wdata = 32'hDEADBEEF;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    step(); step();
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_mem_req", mem_req, 0);
    chk("idle_data_ok", {inst_data_ok, data_data_ok}, 0);
    step();

    // Simultaneous requests: data first, then inst; responses return in that order
    inst_req = 1; data_req = 1; inst_addr = 32'h1C000000; data_addr = 32'h00000100; mem_addr_ok = 1;
    @(negedge clk);
    chk("a1_mem_addr", mem_addr, 32'h100);
    chk("a1_data_addr_ok", data_addr_ok, 1);
    chk("a1_inst_addr_ok", inst_addr_ok, 0);
    step();
    data_req = 0;
    @(negedge clk);
    chk("a2_mem_addr", mem_addr, 32'h1C000000);
    chk("a2_inst_addr_ok", inst_addr_ok, 1);
    step();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hAAAA5555;
    @(negedge clk);
    chk("a3_data_data_ok", data_data_ok, 1);
    chk("a3_inst_data_ok", inst_data_ok, 0);
    chk("a3_data_rdata", data_rdata, 32'hAAAA5555);
    step();
    mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("a4_inst_data_ok", inst_data_ok, 1);
    chk("a4_data_data_ok", data_data_ok, 0);
    chk("a4_inst_rdata", inst_rdata, 32'h12345678);
    step();
    mem_data_ok = 0;
    step();

    // Grant stays with the stalled owner
    data_req = 1; data_addr = 32'h200;
    @(negedge clk);
    chk("b1_mem_addr", mem_addr, 32'h200);
    step();
    inst_req = 1; inst_addr = 32'h300;
    @(negedge clk);
    chk("b2_mem_addr", mem_addr, 32'h200);
    step();
    @(negedge clk);
    chk("b3_mem_addr", mem_addr, 32'h200);
    step();
    mem_addr_ok = 1;
    @(negedge clk);
    chk("b4_data_addr_ok", data_addr_ok, 1);
    step();
    data_req = 0; mem_addr_ok = 0;
    @(negedge clk);
    chk("b5_mem_addr", mem_addr, 32'h300);
    step();
    data_req = 1; data_addr = 32'h400;
    @(negedge clk);
    chk("b6_locked_inst_addr", mem_addr, 32'h300);
    chk("b6_data_addr_ok", data_addr_ok, 0);
    step();
    mem_addr_ok = 1;
    @(negedge clk);
    chk("b7_inst_addr_ok", inst_addr_ok, 1);
    step();
    // Two outstanding: third request must wait for a response
    inst_req = 0;
    @(negedge clk);
    chk("b8_mem_req_full", mem_req, 0);
    step();
    mem_data_ok = 1; mem_rdata = 32'h11;
    @(negedge clk);
    chk("b9_mem_req_full", mem_req, 0);
    chk("b9_data_data_ok", data_data_ok, 1);
    step();
    mem_data_ok = 0;
    @(negedge clk);
    chk("b10_mem_req", mem_req, 1);
    chk("b10_data_addr_ok", data_addr_ok, 1);
    chk("b10_mem_addr", mem_addr, 32'h400);
    step();
    // Reset with two outstanding discards them
    data_req = 0; mem_addr_ok = 0; resetn = 0;
    step();
    resetn = 1; mem_data_ok = 1;
    @(negedge clk);
    chk("b12_no_data_ok", {inst_data_ok, data_data_ok}, 0);
    step();
    mem_data_ok = 0;
    step();

    // Push and pop in the same cycle
    data_req = 1; data_addr = 32'h500; mem_addr_ok = 1;
    step();
    data_req = 0; inst_req = 1; inst_addr = 32'h600; mem_data_ok = 1; mem_rdata = 32'h22;
    @(negedge clk);
    chk("d2_inst_addr_ok", inst_addr_ok, 1);
    chk("d2_data_data_ok", data_data_ok, 1);
    step();
    inst_req = 0; mem_rdata = 32'h33;
    @(negedge clk);
    chk("d3_inst_data_ok", inst_data_ok, 1);
    step();
    @(negedge clk);
    chk("d4_empty_no_data_ok", {inst_data_ok, data_data_ok}, 0);
    step();
    mem_data_ok = 0;
    step();

    // Continuous contention with responses flowing
    inst_req = 1; data_req = 1; inst_addr = 32'h700; data_addr = 32'h800;
    mem_addr_ok = 1; mem_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      logic exp_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp_d = (i % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      @(negedge clk);
      chk("e_data_addr_ok", data_addr_ok, exp_d);
      chk("e_inst_addr_ok", inst_addr_ok, !exp_d);
      step();
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    step();
    mem_data_ok = 0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
